// File: rtl/nor_tree_pkg.sv
// Shared sizing helpers for the pipelined NOR/OR reduction tree.
// Tree depth and per-level node counts are elaboration-time constants.
package nor_tree_pkg;

  // Number of tree levels (= pipeline stages) needed to reduce n operands with fan-in r.
  function automatic int clog_radix(input int n, input int r);
    int lat;
    int cnt;
    lat = 0;
    cnt = n;
    while (cnt > 1) begin
      cnt = (cnt + r - 1) / r;
      lat++;
    end
    if (lat < 1) begin
      lat = 1;
    end
    return lat;
  endfunction

  // Number of nodes produced at tree level lvl (level 0 consumes the raw operands).
  function automatic int nodes_at_level(input int n, input int r, input int lvl);
    int cnt;
    cnt = n;
    for (int i = 0; i <= lvl; i++) begin
      cnt = (cnt + r - 1) / r;
    end
    return cnt;
  endfunction

  function automatic bit params_legal(input int n, input int r);
    return (n >= 2) && (r >= 2) && (r <= 4);
  endfunction

endpackage

// File: rtl/or_node.sv
// One tree node: bitwise OR of RADIX operands; unused slots are tied to zero by the caller.
module or_node #(
  parameter int WIDTH = 8,
  parameter int RADIX = 3
) (
  input  logic [RADIX*WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0]       res_o
);

  always_comb begin
    res_o = '0;
    for (int k = 0; k < RADIX; k++) begin
      res_o = res_o | opnd_i[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/nor_tree_pipe.sv
// Pipelined NUM_IN x WIDTH NOR/OR reduction with one register per tree level and a
// single global advance shared by every stage for valid/ready flow control.
module nor_tree_pipe
  import nor_tree_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 9,
  parameter int RADIX  = 3
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NUM_IN*WIDTH-1:0] IN,
  input  logic                    INV,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  output logic [WIDTH-1:0]        Y,
  output logic                    ALL_ZERO,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY
);

  localparam int LAT   = clog_radix(NUM_IN, RADIX);
  localparam int N0    = nodes_at_level(NUM_IN, RADIX, 0);
  localparam int DEPTH = (LAT > 1) ? LAT - 1 : 1;

  if (!params_legal(NUM_IN, RADIX)) begin : g_bad_params
    $error("nor_tree_pipe: NUM_IN must be >= 2 and RADIX must be 2..4");
  end

  logic             adv_s;
  logic [WIDTH-1:0] node_s [DEPTH][N0];
  logic [WIDTH-1:0] data_q [DEPTH][N0];
  logic [WIDTH-1:0] root_s;
  logic [DEPTH-1:0] vld_q, vld_d, inv_q, inv_d;
  logic             fin_vld_s, fin_inv_s;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d, ov_q;

  assign adv_s    = ~ov_q | OUT_READY;
  assign IN_READY = adv_s;

  for (genvar l = 0; l < LAT; l++) begin : g_lvl
    localparam int NL = nodes_at_level(NUM_IN, RADIX, l);
    localparam int NP = (l == 0) ? NUM_IN : nodes_at_level(NUM_IN, RADIX, l - 1);
    for (genvar j = 0; j < N0; j++) begin : g_node
      if (j < NL) begin : g_used
        logic [RADIX*WIDTH-1:0] opnd_s;
        // Slots past the previous level's node count are the zero padding.
        for (genvar k = 0; k < RADIX; k++) begin : g_opnd
          if (j*RADIX + k >= NP) begin : g_zero
            assign opnd_s[k*WIDTH +: WIDTH] = '0;
          end else if (l == 0) begin : g_in
            assign opnd_s[k*WIDTH +: WIDTH] = IN[(j*RADIX + k)*WIDTH +: WIDTH];
          end else begin : g_prev
            assign opnd_s[k*WIDTH +: WIDTH] = data_q[l-1][j*RADIX + k];
          end
        end
        if (l == LAT - 1) begin : g_root
          or_node #(.WIDTH(WIDTH), .RADIX(RADIX)) u_node (.opnd_i(opnd_s), .res_o(root_s));
        end else begin : g_mid
          or_node #(.WIDTH(WIDTH), .RADIX(RADIX)) u_node (.opnd_i(opnd_s), .res_o(node_s[l][j]));
        end
      end else if (l < LAT - 1) begin : g_pad
        assign node_s[l][j] = '0;
      end
    end
  end

  // The final stage takes its polarity/valid from the last intermediate stage, or from the input when the tree is one level deep.
  if (LAT == 1) begin : g_fin_direct
    assign fin_vld_s = IN_VALID;
    assign fin_inv_s = INV;
  end else begin : g_fin_piped
    assign fin_vld_s = vld_q[LAT-2];
    assign fin_inv_s = inv_q[LAT-2];
  end

  // Next-state for side-band shift registers and the registered result.
  always_comb begin
    vld_d  = (vld_q << 1) | DEPTH'(IN_VALID);
    inv_d  = (inv_q << 1) | DEPTH'(INV);
    y_d    = fin_inv_s ? ~root_s : root_s;
    zero_d = ~|root_s;
  end

  // All stages shift together on adv_s and hold otherwise; RST clears every stage.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_q  <= '0;
      inv_q  <= '0;
      y_q    <= '0;
      zero_q <= 1'b0;
      ov_q   <= 1'b0;
      for (int d = 0; d < DEPTH; d++) begin
        for (int j = 0; j < N0; j++) begin
          data_q[d][j] <= '0;
        end
      end
    end else if (adv_s) begin
      vld_q  <= vld_d;
      inv_q  <= inv_d;
      y_q    <= y_d;
      zero_q <= zero_d;
      ov_q   <= fin_vld_s;
      for (int d = 0; d < DEPTH; d++) begin
        for (int j = 0; j < N0; j++) begin
          data_q[d][j] <= node_s[d][j];
        end
      end
    end else begin
      ov_q <= ov_q;
    end
  end

  assign Y         = y_q;
  assign ALL_ZERO  = zero_q;
  assign OUT_VALID = ov_q;

endmodule

// File: tb/tb_nor_tree_pipe.sv
// Scoreboard bench: a 9x8/radix-3 instance (LAT=2) and a 5x8/radix-2 instance (LAT=3)
// share handshake stimulus; expected results are queued on accept and popped on output.
module tb_nor_tree_pipe;

  logic        clk = 1'b0;
  logic        rst, inv, in_valid, out_ready;
  logic [71:0] a_in;
  logic [39:0] b_in;
  logic        a_ir, a_az, a_ov, b_ir, b_az, b_ov;
  logic [7:0]  a_y, b_y;

  always #5 clk = ~clk;

  nor_tree_pipe #(.WIDTH(8), .NUM_IN(9), .RADIX(3)) u_a (
    .CLK(clk), .RST(rst), .IN(a_in), .INV(inv), .IN_VALID(in_valid), .IN_READY(a_ir),
    .Y(a_y), .ALL_ZERO(a_az), .OUT_VALID(a_ov), .OUT_READY(out_ready));

  nor_tree_pipe #(.WIDTH(8), .NUM_IN(5), .RADIX(2)) u_b (
    .CLK(clk), .RST(rst), .IN(b_in), .INV(inv), .IN_VALID(in_valid), .IN_READY(b_ir),
    .Y(b_y), .ALL_ZERO(b_az), .OUT_VALID(b_ov), .OUT_READY(out_ready));

  typedef struct packed {
    logic [8:0]  exp;
    int unsigned cyc;
  } ent_t;

  ent_t        q [2][$];
  int          n_chk = 0;
  int          n_pass = 0;
  int unsigned cyc = 0;
  bit          lat_chk = 1'b1;
  logic [7:0]  prev_y [2];
  bit          prev_stall [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Reference: per-lane OR of n operands; returns {all_zero, y}.
  function automatic logic [8:0] ref_red(input logic [71:0] v, input int n, input logic iv);
    logic [7:0] o;
    o = 8'h00;
    for (int k = 0; k < n; k++) o = o | v[k*8 +: 8];
    return {~|o, (iv ? ~o : o)};
  endfunction

  function automatic logic [71:0] sparse72();
    logic [95:0] a, b, c;
    a = {$urandom(), $urandom(), $urandom()};
    b = {$urandom(), $urandom(), $urandom()};
    c = {$urandom(), $urandom(), $urandom()};
    return 72'(a & b & c);
  endfunction

  task automatic mon(input int id, input logic ov, input logic ir, input logic [7:0] y,
                     input logic az, input logic [71:0] vin, input int n, input int lat);
    ent_t e;
    if (rst) begin
      q[id].delete();
      prev_stall[id] = 1'b0;
      return;
    end
    if (prev_stall[id]) begin
      check_eq("stall_y_hold", {24'h0, y}, {24'h0, prev_y[id]});
      check_eq("stall_valid_hold", {31'h0, ov}, 32'd1);
    end
    if (ov && !out_ready) check_eq("stall_in_ready", {31'h0, ir}, 32'd0);
    if (ov && out_ready) begin
      if (q[id].size() == 0) begin
        check_eq("spurious_out", {31'h0, ov}, 32'd0);
      end else begin
        e = q[id].pop_front();
        check_eq(id == 0 ? "a_result" : "b_result", {23'h0, az, y}, {23'h0, e.exp});
        if (lat_chk) check_eq(id == 0 ? "a_latency" : "b_latency", cyc - e.cyc, lat);
      end
    end
    if (in_valid && ir) begin
      e.exp = ref_red(vin, n, inv);
      e.cyc = cyc;
      q[id].push_back(e);
    end
    prev_stall[id] = ov && !out_ready;
    prev_y[id]     = y;
  endtask

  task automatic step(input logic r, input logic v, input logic iv, input logic ordy,
                      input logic [71:0] av, input logic [39:0] bv);
    @(negedge clk);
    rst = r; in_valid = v; inv = iv; out_ready = ordy; a_in = av; b_in = bv;
    #1;
    mon(0, a_ov, a_ir, a_y, a_az, a_in, 9, 2);
    mon(1, b_ov, b_ir, b_y, b_az, {32'h0, b_in}, 5, 3);
    cyc++;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((q[0].size() != 0 || q[1].size() != 0) && budget < 20) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 72'h0, 40'h0);
      budget++;
    end
    check_eq("a_drained", q[0].size(), 32'd0);
    check_eq("b_drained", q[1].size(), 32'd0);
  endtask

  initial begin
    logic [71:0] av, one72;
    logic [39:0] bv, one40;
    rst = 1'b1; in_valid = 1'b0; inv = 1'b0; out_ready = 1'b1; a_in = '0; b_in = '0;
    prev_stall[0] = 1'b0; prev_stall[1] = 1'b0; prev_y[0] = 8'h00; prev_y[1] = 8'h00;

    step(1'b1, 1'b0, 1'b0, 1'b1, 72'h0, 40'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 72'h0, 40'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 72'h0, 40'h0);
    check_eq("rst_a_valid", {31'h0, a_ov}, 32'd0);
    check_eq("rst_a_y", {24'h0, a_y}, 32'h00);
    check_eq("rst_a_zero", {31'h0, a_az}, 32'd0);
    check_eq("rst_a_ready", {31'h0, a_ir}, 32'd1);
    check_eq("rst_b_valid", {31'h0, b_ov}, 32'd0);
    check_eq("rst_b_ready", {31'h0, b_ir}, 32'd1);

    // NOR of all-zero operands: one result, two cycles later, for exactly one cycle.
    step(1'b0, 1'b1, 1'b1, 1'b1, 72'h0, 40'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 72'h0, 40'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 72'h0, 40'h0);
    check_eq("nor0_valid", {31'h0, a_ov}, 32'd1);
    check_eq("nor0_y", {24'h0, a_y}, 32'hFF);
    check_eq("nor0_zero", {31'h0, a_az}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 72'h0, 40'h0);
    check_eq("nor0_once", {31'h0, a_ov}, 32'd0);
    drain();

    // Single-bit sweep streamed back to back, both polarities.
    one72 = 72'h1;
    one40 = 40'h1;
    for (int b = 0; b < 72; b++) begin
      for (int p = 0; p < 2; p++) begin
        step(1'b0, 1'b1, p[0], 1'b1, one72 << b, one40 << (b % 40));
      end
    end
    drain();

    // Random back-to-back stream.
    for (int i = 0; i < 16; i++) begin
      av = sparse72();
      bv = sparse72()[39:0];
      step(1'b0, 1'b1, 1'($urandom_range(1)), 1'b1, av, bv);
    end
    drain();

    // Backpressure: 5-cycle stall in the middle of a continuous input stream.
    lat_chk = 1'b0;
    for (int i = 0; i < 16; i++) begin
      av = sparse72();
      bv = sparse72()[39:0];
      step(1'b0, 1'b1, 1'($urandom_range(1)), !(i >= 5 && i < 10), av, bv);
    end
    drain();
    lat_chk = 1'b1;

    // Reset with results in flight: nothing may emerge, then a fresh stream must be correct.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, sparse72(), 40'hFF_0000_0001 << i);
    end
    step(1'b1, 1'b1, 1'b1, 1'b1, 72'h0, 40'h0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 72'h0, 40'h0);
      check_eq("flush_a_valid", {31'h0, a_ov}, 32'd0);
      check_eq("flush_b_valid", {31'h0, b_ov}, 32'd0);
    end
    for (int i = 0; i < 12; i++) begin
      av = sparse72();
      bv = sparse72()[39:0];
      step(1'b0, 1'($urandom_range(3) != 0), 1'($urandom_range(1)), 1'b1, av, bv);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/nor_tree_pipe.md
# nor_tree_pipe

Parametrised, pipelined N-input bitwise NOR/OR reduction for the standard-cell library datapath flow. It generalises the fixed 3-input NOR cell to NUM_IN inputs of WIDTH bits each, reduced by a radix-RADIX OR tree with one register per tree level. A selectable output polarity (NOR or OR) travels with each operand set. Valid/ready flow control lets it sit between handshaked producers and consumers, for example in zero-detect and flag-merge logic.

## Interface
- WIDTH, 8: bits per input operand; every bit lane is reduced independently.
- NUM_IN, 9: number of operands; must be 2 or more.
- RADIX, 3: fan-in of each tree node, 2 to 4; RADIX=3 matches the library's 3-input cells.
- LAT (derived, localparam): ceil(log_RADIX(NUM_IN)), minimum 1; equals the number of pipeline stages.
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous, active-high reset.
- IN  in  NUM_IN*WIDTH  packed operands; operand k is IN[k*WIDTH +: WIDTH].
- INV  in  1  1 = NOR result, 0 = OR result; sampled with IN.
- IN_VALID  in  1  operand set is present.
- IN_READY  out  1  block accepts the operand set this cycle.
- Y  out  WIDTH  reduction result.
- ALL_ZERO  out  1  every bit of every operand in this result was 0; independent of INV.
- OUT_VALID  out  1  Y and ALL_ZERO are valid.
- OUT_READY  in  1  consumer accepts Y.

## Operation
- Level 0 groups operands into ceil(NUM_IN/RADIX) nodes. Each node ORs up to RADIX operands bitwise. The last node is padded with zeros when NUM_IN mod RADIX ≠ 0.
- Each following level reduces the previous level's nodes the same way until one node remains.
- Every level's result is registered. Each stage carries data, INV and valid.
- The final stage computes Y = INV ? ~or_result : or_result and ALL_ZERO = ~|or_result. Both are registered in the last stage.
- Flow control uses a single global advance: adv = ~OUT_VALID | OUT_READY.
  - IN_READY = adv.
  - When adv=1, all stages shift forward. Stage 0 loads IN/INV with valid = IN_VALID.
  - When adv=0, all stage registers hold.
- Bubbles are allowed. An invalid stage still shifts when adv=1, which collapses bubbles toward the output.

## Timing
- Reset: every stage valid, data and INV register clears to 0. After reset, Y=0, ALL_ZERO=0, OUT_VALID=0 and IN_READY=1.
- Latency is LAT cycles from an accepted IN_VALID&IN_READY to OUT_VALID with no stall. Example: NUM_IN=9, RADIX=3 gives LAT=2.
- Throughput is one result per cycle while OUT_READY=1.
- Stall: while OUT_VALID=1 and OUT_READY=0:
  - Y, ALL_ZERO and OUT_VALID hold stable.
  - IN_READY=0, and input is not captured.
- When OUT_READY and IN_VALID are both 1 in the same cycle as OUT_VALID=1, the output is consumed and a new input is accepted in that same cycle.
- Asserting RST mid-stream discards all in-flight results on the next edge; no partial output is emitted. RST dominates IN_VALID.
- OUT_VALID depends only on registers. IN_READY is combinational from OUT_READY, with no path from IN_VALID.

## Structure
- Package nor_tree_pkg holds:
  - a function clog_radix(n, r) that returns LAT;
  - a function nodes_at_level(n, r, lvl);
  - parameter legality checks that error on NUM_IN<2 or RADIX outside 2..4.
- One sub-module, or_node: a combinational RADIX×WIDTH OR with zero padding, instantiated per node via generate loops. The top module owns all registers and the handshake.

## Test plan
- Reset check (WIDTH=8, NUM_IN=9, RADIX=3): hold RST for 2 cycles → OUT_VALID=0, Y=8'h00, ALL_ZERO=0 and IN_READY=1 on the first cycle after release.
- NOR all-zero: IN all 0, INV=1, OUT_READY=1 → 2 cycles later Y=8'hFF, ALL_ZERO=1, OUT_VALID for exactly 1 cycle.
- Single-bit sensitivity: operand 8 = 8'h80, others 0, INV=1 → Y=8'h7F, ALL_ZERO=0. Repeat with INV=0 → Y=8'h80. Sweep all 72 single bits.
- Back-to-back streaming: 16 random sets on consecutive cycles with OUT_READY=1 → 16 results in order, no gaps, each matching the reference model ~|/| per lane.
- Backpressure: drop OUT_READY for 5 cycles mid-stream → Y is stable, IN_READY=0 throughout, no loss or duplication after release.
- Non-divisible tree and reset mid-run: NUM_IN=5, RADIX=2 (LAT=3) with random traffic; assert RST while 3 results are in flight → none emerge, and a fresh stream afterwards is correct.
